// File: rtl/joy_serial_decoder_pkg.sv
// Shared definitions for the joystick serial decoder: FSM state encoding
// and constant-width helpers used to size counters from parameters.
package joy_serial_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_LO  = 3'd1,
        ST_LOAD_HI  = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_SHIFT_HI = 3'd4,
        ST_UPDATE   = 3'd5
    } joy_fsm_e;

    // Ceiling log2; returns 0 for values 0 and 1.
    function automatic int unsigned joy_clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned joy_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/joy_tick_gen.sv
// Modulo-N counter with a single-cycle terminal-count tick.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous restart to zero
//   tick_c     : high while the count sits at N-1 (combinational)
module joy_tick_gen #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick_c
);

    logic [W-1:0] cnt;

    assign tick_c = (cnt == W'(N - 1));

    // Wrap at N-1; a restart wins over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/joy_serial_decoder.sv
// Serial joystick decoder for a daisy-chained 74HC165-style shift chain.
// Loads the chain, clocks out NCHAN*BITS_PER_CHAN active-low buttons
// MSB-first and publishes them active-high on joy_state (channel 0 on top).
//   sysclk, power_on_reset_n : clock, asynchronous active-low reset
//   scan_en     : allow new frames; a running frame always completes
//   joy_data    : serial data from the chain (active-low buttons)
//   joy_clk     : chain shift clock, idles low
//   joy_load_n  : chain parallel load, active-low, idles high
//   joy_state   : decoded button state
//   frame_valid : one-cycle pulse in the cycle joy_state takes a new frame
// Optional build macro JOYDEC_DEBOUNCE_EN: publish a frame only when it
// matches the previously captured frame.
module joy_serial_decoder
    import joy_serial_decoder_pkg::*;
#(
    parameter int unsigned NCHAN         = 2,
    parameter int unsigned BITS_PER_CHAN = 8,
    parameter int unsigned CLKDIV        = 14,
    parameter int unsigned SCAN_CYCLES   = 28000
) (
    input  logic                             sysclk,
    input  logic                             power_on_reset_n,
    input  logic                             scan_en,
    input  logic                             joy_data,
    output logic                             joy_clk,
    output logic                             joy_load_n,
    output logic [NCHAN*BITS_PER_CHAN-1:0]   joy_state,
    output logic                             frame_valid
);

    localparam int unsigned TOTAL   = NCHAN * BITS_PER_CHAN;
    localparam int unsigned CNT_W   = joy_clog2(TOTAL + 1);
    localparam int unsigned TMR_RAW = joy_clog2(joy_max(SCAN_CYCLES, CLKDIV));
    localparam int unsigned TMR_W   = (TMR_RAW < 1) ? 1 : TMR_RAW;

    joy_fsm_e           state;
    joy_fsm_e           state_nxt;
    logic               scan_tick_c;
    logic               hp_tick_c;
    logic               hp_clr_c;
    logic               start_c;
    logic               samp_c;
    logic               pend;
    logic [1:0]         sync;
    logic [CNT_W-1:0]   bit_cnt;
    logic [TOTAL-1:0]   shift_reg;
`ifdef JOYDEC_DEBOUNCE_EN
    logic [TOTAL-1:0]   ref_frame;
`endif

    // Frame-start timer, free-running from reset.
    joy_tick_gen #(.N(SCAN_CYCLES), .W(TMR_W)) u_scan_tmr (
        .clk    (sysclk),
        .rst_n  (power_on_reset_n),
        .clr    (1'b0),
        .tick_c (scan_tick_c)
    );

    // Half-period timer, realigned whenever the FSM changes state.
    joy_tick_gen #(.N(CLKDIV), .W(TMR_W)) u_hp_tmr (
        .clk    (sysclk),
        .rst_n  (power_on_reset_n),
        .clr    (hp_clr_c),
        .tick_c (hp_tick_c)
    );

    assign start_c  = (scan_tick_c || pend) && scan_en;
    assign hp_clr_c = (state_nxt != state);
    assign samp_c   = ~sync[1];

    // FSM state register.
    always_ff @(posedge sysclk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start_c)   state_nxt = ST_LOAD_LO;
            ST_LOAD_LO:  if (hp_tick_c) state_nxt = ST_LOAD_HI;
            ST_LOAD_HI:  if (hp_tick_c) state_nxt = ST_SHIFT_LO;
            ST_SHIFT_LO: if (hp_tick_c) state_nxt = ST_SHIFT_HI;
            ST_SHIFT_HI: begin
                if (hp_tick_c) begin
                    state_nxt = (bit_cnt == CNT_W'(TOTAL)) ? ST_UPDATE : ST_SHIFT_LO;
                end
            end
            ST_UPDATE:   state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Chain strobes are decoded from the next state so each register
    // output lines up exactly with the state it belongs to.
    always_ff @(posedge sysclk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            joy_clk    <= 1'b0;
            joy_load_n <= 1'b1;
            sync       <= 2'b11;
        end else begin
            joy_clk    <= (state_nxt == ST_SHIFT_HI);
            joy_load_n <= (state_nxt != ST_LOAD_LO);
            sync       <= {sync[0], joy_data};
        end
    end

    // Ticks arriving mid-frame are remembered; a tick seen while idle
    // with scanning disabled is dropped so re-enable waits for a new tick.
    always_ff @(posedge sysclk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            pend <= 1'b0;
        end else if (state == ST_IDLE) begin
            pend <= 1'b0;
        end else if (scan_tick_c) begin
            pend <= 1'b1;
        end
    end

    // Sample on the last cycle of the low half-period; shifting left means
    // the first sample ends up in the top bit after TOTAL samples.
    always_ff @(posedge sysclk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (state == ST_IDLE) begin
            bit_cnt   <= '0;
        end else if ((state == ST_SHIFT_LO) && hp_tick_c) begin
            bit_cnt   <= bit_cnt + CNT_W'(1);
            shift_reg <= (shift_reg << 1) | TOTAL'(samp_c);
        end
    end

    // Publish the captured frame as the FSM enters UPDATE.
    always_ff @(posedge sysclk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            joy_state   <= '0;
            frame_valid <= 1'b0;
`ifdef JOYDEC_DEBOUNCE_EN
            ref_frame   <= '1;
`endif
        end else begin
            frame_valid <= 1'b0;
            if ((state_nxt == ST_UPDATE) && (state != ST_UPDATE)) begin
`ifdef JOYDEC_DEBOUNCE_EN
                if (shift_reg == ref_frame) begin
                    joy_state   <= shift_reg;
                    frame_valid <= 1'b1;
                end else begin
                    ref_frame   <= shift_reg;
                end
`else
                joy_state   <= shift_reg;
                frame_valid <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_joy_serial_decoder.sv
module tb_joy_serial_decoder;

    localparam int unsigned SCAN   = 400;
    localparam int unsigned SCAN_O = 50;

    logic        sysclk = 1'b0;
    logic        rst_n;
    logic        scan_en;

    logic        jd, jc, jl, fv;
    logic [15:0] js;
    logic        jd_o, jc_o, jl_o, fv_o;
    logic [15:0] js_o;

    logic [15:0] pat   = 16'hFFFF;
    logic [15:0] pat_o = 16'hFFFF;
    logic [15:0] chain   = 16'hFFFF;
    logic [15:0] chain_o = 16'hFFFF;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int t_load = 0;
    int loads  = 0;
    int rises  = 0;
    int rises_at_load = 0;
    int fv_cnt = 0;
    logic jl_prev = 1'b1;

    always #5 sysclk = ~sysclk;

    joy_serial_decoder #(.NCHAN(2), .BITS_PER_CHAN(8), .CLKDIV(4), .SCAN_CYCLES(SCAN)) dut (
        .sysclk           (sysclk),
        .power_on_reset_n (rst_n),
        .scan_en          (scan_en),
        .joy_data         (jd),
        .joy_clk          (jc),
        .joy_load_n       (jl),
        .joy_state        (js),
        .frame_valid      (fv)
    );

    joy_serial_decoder #(.NCHAN(2), .BITS_PER_CHAN(8), .CLKDIV(4), .SCAN_CYCLES(SCAN_O)) dut_o (
        .sysclk           (sysclk),
        .power_on_reset_n (rst_n),
        .scan_en          (1'b1),
        .joy_data         (jd_o),
        .joy_clk          (jc_o),
        .joy_load_n       (jl_o),
        .joy_state        (js_o),
        .frame_valid      (fv_o)
    );

    // 74HC165 chain models: parallel load on load_n low, shift on clk rise.
    always @(posedge jc or negedge jl) begin
        if (!jl) chain <= pat;
        else     chain <= {chain[14:0], 1'b1};
    end
    assign jd = chain[15];

    always @(posedge jc_o or negedge jl_o) begin
        if (!jl_o) chain_o <= pat_o;
        else       chain_o <= {chain_o[14:0], 1'b1};
    end
    assign jd_o = chain_o[15];

    always @(posedge sysclk) cyc <= cyc + 1;
    always @(posedge jc) rises <= rises + 1;

    always @(negedge sysclk) begin
        if (jl_prev && !jl) begin
            t_load        = cyc;
            loads         = loads + 1;
            rises_at_load = rises;
        end
        jl_prev = jl;
        if (fv === 1'b1) fv_cnt = fv_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_fv(input bit which, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge sysclk);
            if ((which ? fv_o : fv) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_load(input int bound, output bit ok);
        int n0;
        n0 = loads;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge sysclk);
            if (loads != n0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(js), 32'h0);
        check({tag, "_clk"},   32'(jc), 32'h0);
        check({tag, "_load"},  32'(jl), 32'h1);
        check({tag, "_fv"},    32'(fv), 32'h0);
    endtask

`ifndef JOYDEC_DEBOUNCE_EN
    typedef struct {
        logic [15:0] pat;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [6];

    initial begin
        bit ok;
        int t_ref, t_raise, t_exp, n1, g;

        tbl[0] = '{16'h7FFE, 16'h8001};
        tbl[1] = '{16'hFFFF, 16'h0000};
        tbl[2] = '{16'h0000, 16'hFFFF};
        tbl[3] = '{16'hA55A, 16'h5AA5};
        tbl[4] = '{16'h1234, 16'hEDCB};
        tbl[5] = '{16'hFF00, 16'h00FF};

        rst_n   = 1'b0;
        scan_en = 1'b1;
        pat     = tbl[0].pat;
        pat_o   = 16'h00FF;

        // Outputs held at reset values while reset is asserted.
        for (int i = 0; i < 2; i++) begin
            repeat (3) @(negedge sysclk);
            check_reset_outputs("reset");
        end
        @(negedge sysclk);
        rst_n = 1'b1;

        // Table frames: data, load-to-valid latency, clock count, pulse width.
        for (int v = 0; v < 6; v++) begin
            pat = tbl[v].pat;
            wait_fv(1'b0, 600, ok);
            if (!ok) begin
                check($sformatf("vec%0d_fv_timeout", v), 32'h0, 32'h1);
            end else begin
                check($sformatf("vec%0d_state", v), 32'(js), 32'(tbl[v].exp));
                check($sformatf("vec%0d_latency", v), 32'(cyc - t_load), 32'd136);
                check($sformatf("vec%0d_clk_rises", v), 32'(rises - rises_at_load), 32'd16);
                @(negedge sysclk);
                check($sformatf("vec%0d_fv_one_cycle", v), 32'(fv), 32'h0);
            end
        end

        // Scan gating: drop scan_en mid-shift, frame still completes.
        pat = 16'h5A0F;
        wait_load(600, ok);
        check("gate_load_seen", 32'(ok), 32'h1);
        repeat (40) @(negedge sysclk);
        scan_en = 1'b0;
        wait_fv(1'b0, 200, ok);
        check("gate_fv_seen", 32'(ok), 32'h1);
        check("gate_state", 32'(js), 32'h0000A5F0);
        t_ref = t_load;
        n1    = loads;
        repeat (1000) @(negedge sysclk);
        check("gate_no_load", 32'(loads), 32'(n1));
        scan_en = 1'b1;
        t_raise = cyc;
        pat     = 16'h0F0F;
        t_exp   = t_ref + int'(SCAN) * ((t_raise - t_ref) / int'(SCAN) + 1);
        wait_load(600, ok);
        check("regate_load_seen", 32'(ok), 32'h1);
        check("regate_load_time", 32'(t_load), 32'(t_exp));
        wait_fv(1'b0, 200, ok);
        check("regate_fv_seen", 32'(ok), 32'h1);
        check("regate_state", 32'(js), 32'h0000F0F0);

        // Reset in the middle of bit 7 aborts the frame.
        pat = 16'hC3C3;
        wait_load(600, ok);
        check("midrst_load_seen", 32'(ok), 32'h1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sysclk);
            if (rises - rises_at_load == 7) begin
                ok = 1'b1;
                break;
            end
        end
        check("midrst_bit7_seen", 32'(ok), 32'h1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (5) @(negedge sysclk);
        rst_n = 1'b1;
        pat   = 16'h3C96;
        wait_fv(1'b0, 700, ok);
        check("postrst_fv_seen", 32'(ok), 32'h1);
        check("postrst_state", 32'(js), 32'h0000C369);
        check("postrst_latency", 32'(cyc - t_load), 32'd136);

        // Overrun: frames longer than the scan period run back to back.
        for (int k = 0; k < 3; k++) begin
            wait_fv(1'b1, 400, ok);
            if (!ok) begin
                check($sformatf("ovr%0d_fv_timeout", k), 32'h0, 32'h1);
            end else begin
                check($sformatf("ovr%0d_state", k), 32'(js_o), 32'h0000FF00);
                g = 0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge sysclk);
                    g = g + 1;
                    if (jl_o === 1'b0) break;
                end
                check($sformatf("ovr%0d_gap", k), 32'(g), 32'd2);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
`else
    initial begin
        bit ok;
        logic [15:0] dpat [4];
        logic [15:0] dexp [4];

        dpat[0] = 16'hF0F0;  dexp[0] = 16'h0000;
        dpat[1] = 16'h33CC;  dexp[1] = 16'h0000;
        dpat[2] = 16'h33CC;  dexp[2] = 16'hCC33;
        dpat[3] = 16'h5555;  dexp[3] = 16'hCC33;

        rst_n   = 1'b0;
        scan_en = 1'b1;
        pat     = dpat[0];
        pat_o   = 16'h00FF;
        repeat (3) @(negedge sysclk);
        check_reset_outputs("reset");
        @(negedge sysclk);
        rst_n = 1'b1;

        // Frames A,B,B,C: only the repeated B is published.
        for (int i = 0; i < 4; i++) begin
            wait_load(600, ok);
            check($sformatf("db%0d_load_seen", i), 32'(ok), 32'h1);
            for (int j = 0; j < 20; j++) begin
                @(negedge sysclk);
                if (jl === 1'b1) break;
            end
            if (i < 3) pat = dpat[i + 1];
            repeat (150) @(negedge sysclk);
            check($sformatf("db%0d_state", i), 32'(js), 32'(dexp[i]));
        end
        check("db_fv_count", 32'(fv_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
`endif

endmodule
